// File: rtl/gemm_issue_ctrl.sv
// gemm_issue_ctrl: buffers GEMM commands in a small FIFO and issues them one
// at a time to the GEMM engine controller, tracking ack, run and completion.
// Each accepted command yields one completion record carrying its tag and the
// number of result rows seen. The exception is a command the engine never
// acknowledges: it is dropped and the sticky err_no_ack flag is raised.
module gemm_issue_ctrl #(
   parameter int BLOCK_SIZE_WIDTH = 6,
   parameter int TAG_WIDTH        = 4,
   parameter int FIFO_DEPTH       = 4,
   parameter int ROW_CNT_WIDTH    = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [BLOCK_SIZE_WIDTH-1:0] cmd_block_size,
   input  logic [TAG_WIDTH-1:0]        cmd_tag,
   output logic                        start_op,
   output logic [BLOCK_SIZE_WIDTH-1:0] block_size,
   input  logic                        done,
   input  logic                        r_depend,
   input  logic                        w_depend,
   input  logic                        output_valid,
   output logic                        cmp_valid,
   output logic [TAG_WIDTH-1:0]        cmp_tag,
   output logic [ROW_CNT_WIDTH-1:0]    cmp_rows,
   output logic                        busy,
   output logic                        err_no_ack
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = BLOCK_SIZE_WIDTH + TAG_WIDTH;
   localparam logic [CNT_W-1:0]         DEPTH_C     = CNT_W'(FIFO_DEPTH);
   localparam logic [1:0]               ACK_LIMIT_C = 2'd3;
   localparam logic [ROW_CNT_WIDTH-1:0] ROW_MAX_C   = {ROW_CNT_WIDTH{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_RUN      = 3'd3,
      ST_COMPLETE = 3'd4
   } state_t;

   // Command FIFO storage and bookkeeping
   logic [ENTRY_W-1:0]          fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]            wr_ptr_r;
   logic [PTR_W-1:0]            rd_ptr_r;
   logic [CNT_W-1:0]            count_r;
   logic                        full_s;
   logic                        empty_s;
   logic                        push_s;
   logic                        pop_s;
   logic [ENTRY_W-1:0]          head_s;
   logic [BLOCK_SIZE_WIDTH-1:0] head_bs_s;
   logic [TAG_WIDTH-1:0]        head_tag_s;

   // Issue FSM and per-command tracking
   state_t                      state_r;
   state_t                      next_state_s;
   logic [1:0]                  ack_cnt_r;
   logic                        ack_timeout_s;
   logic [ROW_CNT_WIDTH-1:0]    row_cnt_r;
   logic [ROW_CNT_WIDTH-1:0]    row_next_s;
   logic [TAG_WIDTH-1:0]        tag_r;

   assign full_s     = (count_r == DEPTH_C);
   assign empty_s    = (count_r == {CNT_W{1'b0}});
   assign push_s     = cmd_valid & ~full_s;
   assign pop_s      = (state_r == ST_ISSUE) & ~empty_s;
   assign head_s     = fifo_mem_r[rd_ptr_r];
   assign head_bs_s  = head_s[ENTRY_W-1:TAG_WIDTH];
   assign head_tag_s = head_s[TAG_WIDTH-1:0];

   assign cmd_ready  = ~full_s;
   assign busy       = ~empty_s | (state_r != ST_IDLE);

   // FIFO payload write; contents need no reset because occupancy gates reads
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= {cmd_block_size, cmd_tag};
      end else begin
         fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Next-state decode, including the no-ack timeout out of WAIT_ACK
   always_comb begin
      next_state_s  = state_r;
      ack_timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s && done && !r_depend && !w_depend) begin
               next_state_s = ST_ISSUE;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            next_state_s = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (!done) begin
               next_state_s = ST_RUN;
            end else if (ack_cnt_r == ACK_LIMIT_C) begin
               next_state_s  = ST_IDLE;
               ack_timeout_s = 1'b1;
            end else begin
               next_state_s = ST_WAIT_ACK;
            end
         end
         ST_RUN: begin
            if (done) begin
               next_state_s = ST_COMPLETE;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_COMPLETE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Row counter next value: counts output_valid in RUN, saturating at all-ones
   always_comb begin
      row_next_s = row_cnt_r;
      if ((state_r == ST_RUN) && output_valid && (row_cnt_r != ROW_MAX_C)) begin
         row_next_s = row_cnt_r + ROW_CNT_WIDTH'(1);
      end else begin
         row_next_s = row_cnt_r;
      end
   end

   // FSM state, tracking registers and registered outputs. start_op and
   // cmp_valid are decoded from the next state so that they are high during
   // the ISSUE and COMPLETE cycles themselves. cmp_rows therefore includes a
   // row that arrives in the same cycle as the done that ends RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         ack_cnt_r  <= 2'd0;
         row_cnt_r  <= {ROW_CNT_WIDTH{1'b0}};
         tag_r      <= {TAG_WIDTH{1'b0}};
         start_op   <= 1'b0;
         block_size <= {BLOCK_SIZE_WIDTH{1'b0}};
         cmp_valid  <= 1'b0;
         cmp_tag    <= {TAG_WIDTH{1'b0}};
         cmp_rows   <= {ROW_CNT_WIDTH{1'b0}};
         err_no_ack <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         start_op  <= (next_state_s == ST_ISSUE);
         cmp_valid <= (next_state_s == ST_COMPLETE);

         if (next_state_s == ST_ISSUE) begin
            block_size <= head_bs_s;
         end

         if (state_r == ST_ISSUE) begin
            tag_r     <= head_tag_s;
            row_cnt_r <= {ROW_CNT_WIDTH{1'b0}};
            ack_cnt_r <= 2'd0;
         end else begin
            row_cnt_r <= row_next_s;
            if ((state_r == ST_WAIT_ACK) && done && (ack_cnt_r != ACK_LIMIT_C)) begin
               ack_cnt_r <= ack_cnt_r + 2'd1;
            end
         end

         if (next_state_s == ST_COMPLETE) begin
            cmp_tag  <= tag_r;
            cmp_rows <= row_next_s;
         end

         if (ack_timeout_s) begin
            err_no_ack <= 1'b1;
         end
      end
   end

endmodule
